// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory stage: bus widths, the
// memory-stage state encoding and the big-endian byte-lane helpers.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Byte lanes of a 16-bit word; even byte address maps to the high lane.
  localparam int HI_LANE_MSB = 15;
  localparam int HI_LANE_LSB = 8;
  localparam int LO_LANE_MSB = 7;
  localparam int LO_LANE_LSB = 0;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_LOAD,
    MS_RMW
  } mem_state_e;

  // Replace one byte lane of a word, keeping the other lane intact.
  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                   input logic [7:0]        data,
                                                   input logic              lo_lane);
    logic [DATA_W-1:0] merged;
    merged = word;
    if (lo_lane) merged[LO_LANE_MSB:LO_LANE_LSB] = data;
    else         merged[HI_LANE_MSB:HI_LANE_LSB] = data;
    return merged;
  endfunction

  // Pick one byte lane out of a word.
  function automatic logic [7:0] extract_byte(input logic [DATA_W-1:0] word,
                                              input logic              lo_lane);
    return lo_lane ? word[LO_LANE_MSB:LO_LANE_LSB] : word[HI_LANE_MSB:HI_LANE_LSB];
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// MEM-stage bus between the pipeline (master) and the data memory unit (slave).
interface data_mem_unit_if;
  import cpu_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic              byte_op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              stall;
  logic              misalign;
  logic              req_err;

  modport master (
    output mem_read, mem_write, byte_op, addr, wdata,
    input  rdata, rd_valid, stall, misalign, req_err
  );

  modport slave (
    input  mem_read, mem_write, byte_op, addr, wdata,
    output rdata, rd_valid, stall, misalign, req_err
  );

endinterface

// File: rtl/data_ram.sv
// Synchronous single-port word RAM: write at the clock edge, registered
// read with one cycle of latency (read-before-write on the same index).
module data_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write and registered read port.
  // NOTE: the storage array has no reset so it maps onto a RAM macro; its contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory unit: word/byte loads and stores into a big-endian
// byte-addressed RAM. Loads and byte stores take one stall cycle; byte
// stores are done as a read-modify-write of the containing word.
module data_mem_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_e        state;
  mem_state_e        next_state;

  logic [IDX_W-1:0]  req_idx;
  logic              req_lo;
  logic              req_byte;
  logic [7:0]        req_wbyte;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic [DATA_W-1:0] rdata_q;
  logic              rd_valid_q;
  logic              stall;
  logic              misalign;
  logic              req_err;

  // Address bits above the word index wrap and are deliberately ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+1];

  data_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Next-state, RAM control and request-cycle status decode.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_idx    = req_idx;
    ram_din    = bus.wdata;
    stall      = 1'b0;
    misalign   = 1'b0;
    req_err    = 1'b0;

    case (state)
      MS_IDLE: begin
        ram_idx = bus.addr[IDX_W:1];
        if (bus.mem_read && bus.mem_write) begin
          req_err = 1'b1;
        end else if ((bus.mem_read || bus.mem_write) && !bus.byte_op && bus.addr[0]) begin
          misalign = 1'b1;
        end else if (bus.mem_write && !bus.byte_op) begin
          ram_we = 1'b1;
        end else if (bus.mem_read) begin
          stall      = 1'b1;
          next_state = MS_LOAD;
        end else if (bus.mem_write) begin
          stall      = 1'b1;
          next_state = MS_RMW;
        end
      end
      MS_LOAD: begin
        next_state = MS_IDLE;
      end
      MS_RMW: begin
        ram_we     = 1'b1;
        ram_din    = merge_byte(ram_dout, req_wbyte, req_lo);
        next_state = MS_IDLE;
      end
      default: begin
        next_state = MS_IDLE;
      end
    endcase

    // Reset drops any pending write and releases the pipeline immediately.
    if (rst) begin
      next_state = MS_IDLE;
      ram_we     = 1'b0;
      stall      = 1'b0;
      misalign   = 1'b0;
      req_err    = 1'b0;
    end
  end

  // Capture the request context at the issue edge for use in LOAD/RMW.
  always_ff @(posedge clk) begin
    if (state == MS_IDLE) begin
      req_idx   <= bus.addr[IDX_W:1];
      req_lo    <= bus.addr[0];
      req_byte  <= bus.byte_op;
      req_wbyte <= bus.wdata[7:0];
    end
  end

  // State register plus registered load result and its valid pulse.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MS_IDLE;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= next_state;
      rd_valid_q <= (state == MS_LOAD);
      if (state == MS_LOAD) begin
        rdata_q <= req_byte ? {8'h00, extract_byte(ram_dout, req_lo)} : ram_dout;
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.stall    = stall;
  assign bus.misalign = misalign;
  assign bus.req_err  = req_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit. A transaction-level model (word array,
// last load result) predicts every cycle's outputs; a negedge process
// compares them, and literal checks pin the model at key points.
module tb_data_mem_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_unit_if bus ();

  data_mem_unit #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  logic [15:0] model_mem [256];
  logic [15:0] model_rdata = 16'h0000;
  bit          rdv_next    = 1'b0;
  bit          check_en    = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_stall = 1'b0;
  logic        e_mis   = 1'b0;
  logic        e_err   = 1'b0;
  logic        e_rdv   = 1'b0;
  logic [15:0] e_rdata = 16'h0000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("stall",    16'(bus.stall),    16'(e_stall));
      check("misalign", 16'(bus.misalign), 16'(e_mis));
      check("req_err",  16'(bus.req_err),  16'(e_err));
      check("rd_valid", 16'(bus.rd_valid), 16'(e_rdv));
      check("rdata",    bus.rdata,         e_rdata);
    end
  end

  // Advance one cycle and drive inputs; expectations default to idle.
  task automatic drive_cycle(input logic r, input logic rd, input logic wr, input logic bop,
                             input logic [15:0] a, input logic [15:0] wd);
    @(posedge clk);
    #1;
    rst           = r;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.byte_op   = bop;
    bus.addr      = a;
    bus.wdata     = wd;
    e_rdv         = rdv_next;
    rdv_next      = 1'b0;
    e_rdata       = model_rdata;
    e_stall       = 1'b0;
    e_mis         = 1'b0;
    e_err         = 1'b0;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // One complete access, predicted from the access rules.
  task automatic op(input logic rd, input logic wr, input logic bop,
                    input logic [15:0] a, input logic [15:0] wd);
    logic [7:0]  idx;
    logic [15:0] w;
    idx = a[8:1];
    drive_cycle(1'b0, rd, wr, bop, a, wd);
    if (rd && wr) begin
      e_err = 1'b1;
    end else if ((rd || wr) && !bop && a[0]) begin
      e_mis = 1'b1;
    end else if (wr && !bop) begin
      model_mem[idx] = wd;
    end else if (rd || wr) begin
      e_stall = 1'b1;
      drive_cycle(1'b0, rd, wr, bop, a, wd);
      w = model_mem[idx];
      if (rd) begin
        if (!bop)     model_rdata = w;
        else if (a[0]) model_rdata = {8'h00, w[7:0]};
        else          model_rdata = {8'h00, w[15:8]};
        rdv_next = 1'b1;
      end else begin
        model_mem[idx] = a[0] ? {w[15:8], wd[7:0]} : {wd[7:0], w[7:0]};
      end
    end
  endtask

  // Load, then check the delivered value literally in the following cycle.
  task automatic load_expect(input string name, input logic bop, input logic [15:0] a,
                             input logic [15:0] v);
    op(1'b1, 1'b0, bop, a, 16'h0000);
    idle();
    check(name, bus.rdata, v);
    check({name, "_vld"}, 16'(bus.rd_valid), 16'h0001);
  endtask

  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.byte_op   = 1'b0;
    bus.addr      = 16'h0000;
    bus.wdata     = 16'h0000;

    // Reset.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_en = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle();
    check("reset_rdata", bus.rdata, 16'h0000);

    // sw then lw back-to-back.
    op(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
    load_expect("lw_beef", 1'b0, 16'h0010, 16'hBEEF);

    // Byte loads, back-to-back.
    op(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    load_expect("lbu_11", 1'b1, 16'h0011, 16'h00EF);
    load_expect("lbu_10", 1'b1, 16'h0010, 16'h00BE);

    // Byte stores via read-modify-write, each followed by a word load.
    op(1'b0, 1'b1, 1'b1, 16'h0011, 16'h1234);
    load_expect("sb_lo_merge", 1'b0, 16'h0010, 16'hBE34);
    op(1'b0, 1'b1, 1'b1, 16'h0010, 16'h00AA);
    load_expect("sb_hi_merge", 1'b0, 16'h0010, 16'hAA34);

    // Misaligned word accesses are suppressed.
    op(1'b0, 1'b1, 1'b0, 16'h0012, 16'h5A5A);
    op(1'b1, 1'b0, 1'b0, 16'h0013, 16'h0000);
    #1;
    check("lw_mis_pulse", 16'(bus.misalign), 16'h0001);
    check("lw_mis_rdata", bus.rdata, 16'hAA34);
    op(1'b0, 1'b1, 1'b0, 16'h0013, 16'hFFFF);
    load_expect("sw_mis_nowrite", 1'b0, 16'h0012, 16'h5A5A);

    // Conflicting read+write request is rejected.
    op(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    check("req_err_pulse", 16'(bus.req_err), 16'h0001);
    check("req_err_nostall", 16'(bus.stall), 16'h0000);
    load_expect("req_err_nowrite", 1'b0, 16'h0010, 16'hAA34);

    // Wrap: address bits above the word index are ignored.
    op(1'b0, 1'b1, 1'b0, 16'h0210, 16'h0C0D);
    load_expect("addr_wrap", 1'b0, 16'h0010, 16'h0C0D);

    // Reset during the RMW cycle drops the byte write.
    op(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0055);
    e_stall = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0055);
    #1;
    check("rst_rmw_stall", 16'(bus.stall), 16'h0000);
    model_rdata = 16'h0000;
    idle();
    check("rst_rmw_rdata", bus.rdata, 16'h0000);
    load_expect("rst_rmw_dropped", 1'b0, 16'h0020, 16'h0000);
    load_expect("rst_ram_kept", 1'b0, 16'h0012, 16'h5A5A);

    idle();
    idle();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

endmodule
